// File: rtl/uart_wb_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge.
// Holds the FSM encoding, the command opcodes and the response bytes.
package uart_wb_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWb,
        StResp
    } bridge_state_e;

    localparam logic [7:0] OpWrite     = 8'h57;  // 'W'
    localparam logic [7:0] OpRead      = 8'h52;  // 'R'

    localparam logic [7:0] RespOk      = 8'h4B;  // 'K'
    localparam logic [7:0] RespErr     = 8'h45;  // 'E'
    localparam logic [7:0] RespTimeout = 8'h54;  // 'T'
    localparam logic [7:0] RespUnknown = 8'h3F;  // '?'

endpackage

// File: rtl/bridge_shift32.sv
// Four-byte MSB-first shift register with a 2-bit byte counter.
// Shifts a byte in at the bottom each step, so the top byte is the next one to send out.
module bridge_shift32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [31:0] word_o,
    output logic [1:0]  cnt_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= 32'h0;
            cnt_q  <= 2'd0;
        end else begin
            if (load_i) begin
                word_q <= word_i;
                cnt_q  <= 2'd0;
            end else if (shift_i) begin
                word_q <= {word_q[23:0], byte_i};
                cnt_q  <= cnt_q + 2'd1;
            end
            if (clr_i) begin
                cnt_q <= 2'd0;
            end
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// Byte-stream command bridge: 'W'+addr+data or 'R'+addr from the UART becomes one
// Wishbone classic cycle, answered with a status byte or four read-data bytes.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_ALIGN     = 1
) (
    input  logic        clk_sys_i,
    input  logic        reset_sys_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

    bridge_state_e   state_q, state_d;
    logic            op_q, op_d;          // 1 = write
    logic            cyc_q, cyc_d;
    logic            rdy_q, rdy_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      resp_q, resp_d;
    logic            rd_resp_q, rd_resp_d;

    logic            rx_fire;
    logic            adr_shift, dat_shift, rd_load, rd_shift, cnt_clr;
    logic [31:0]     adr_word, dat_word, rd_word;
    logic [1:0]      adr_cnt, dat_cnt, rd_cnt;

    assign rx_fire = rx_valid_i & rdy_q;

    bridge_shift32 u_adr_sr (
        .clk_i   (clk_sys_i),
        .rst_ni  (reset_sys_n_i),
        .clr_i   (cnt_clr),
        .shift_i (adr_shift),
        .byte_i  (rx_data_i),
        .load_i  (1'b0),
        .word_i  (32'h0),
        .word_o  (adr_word),
        .cnt_o   (adr_cnt)
    );

    bridge_shift32 u_dat_sr (
        .clk_i   (clk_sys_i),
        .rst_ni  (reset_sys_n_i),
        .clr_i   (cnt_clr),
        .shift_i (dat_shift),
        .byte_i  (rx_data_i),
        .load_i  (1'b0),
        .word_i  (32'h0),
        .word_o  (dat_word),
        .cnt_o   (dat_cnt)
    );

    bridge_shift32 u_rd_sr (
        .clk_i   (clk_sys_i),
        .rst_ni  (reset_sys_n_i),
        .clr_i   (cnt_clr),
        .shift_i (rd_shift),
        .byte_i  (8'h00),
        .load_i  (rd_load),
        .word_i  (wb_dat_i),
        .word_o  (rd_word),
        .cnt_o   (rd_cnt)
    );

    always_ff @(posedge clk_sys_i or negedge reset_sys_n_i) begin
        if (!reset_sys_n_i) begin
            state_q   <= StIdle;
            op_q      <= 1'b0;
            cyc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            tmo_q     <= '0;
            resp_q    <= 8'h00;
            rd_resp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cyc_q     <= cyc_d;
            rdy_q     <= rdy_d;
            tmo_q     <= tmo_d;
            resp_q    <= resp_d;
            rd_resp_q <= rd_resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cyc_d     = cyc_q;
        tmo_d     = tmo_q;
        resp_d    = resp_q;
        rd_resp_d = rd_resp_q;
        adr_shift = 1'b0;
        dat_shift = 1'b0;
        rd_load   = 1'b0;
        rd_shift  = 1'b0;
        cnt_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    if (rx_data_i == OpWrite) begin
                        op_d    = 1'b1;
                        state_d = StAddr;
                    end else if (rx_data_i == OpRead) begin
                        op_d    = 1'b0;
                        state_d = StAddr;
                    end else begin
                        resp_d    = RespUnknown;
                        rd_resp_d = 1'b0;
                        state_d   = StResp;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    adr_shift = 1'b1;
                    if (adr_cnt == 2'd3) begin
                        state_d = op_q ? StData : StWb;
                        tmo_d   = '0;
                    end
                end
            end
            StData: begin
                if (rx_fire) begin
                    dat_shift = 1'b1;
                    if (dat_cnt == 2'd3) begin
                        state_d = StWb;
                        tmo_d   = '0;
                    end
                end
            end
            StWb: begin
                // Error takes priority over a simultaneous ack.
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    tmo_d = tmo_q + 1'b1;
                end else if (wb_err_i) begin
                    cyc_d     = 1'b0;
                    resp_d    = RespErr;
                    rd_resp_d = 1'b0;
                    state_d   = StResp;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = StResp;
                    if (op_q) begin
                        resp_d    = RespOk;
                        rd_resp_d = 1'b0;
                    end else begin
                        rd_load   = 1'b1;
                        rd_resp_d = 1'b1;
                    end
                end else if (tmo_q == TmoMax) begin
                    cyc_d     = 1'b0;
                    resp_d    = RespTimeout;
                    rd_resp_d = 1'b0;
                    state_d   = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StResp: begin
                if (tx_ready_i) begin
                    if (rd_resp_q) begin
                        rd_shift = 1'b1;
                        if (rd_cnt == 2'd3) begin
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                    if (state_d == StIdle) begin
                        cnt_clr = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so ready stays low while reset is asserted and rises one edge after release.
        rdy_d = (state_d == StIdle) || (state_d == StAddr) || (state_d == StData);
    end

    assign rx_ready_o = rdy_q;
    assign tx_valid_o = (state_q == StResp);
    assign tx_data_o  = rd_resp_q ? rd_word[31:24] : resp_q;
    assign busy_o     = (state_q != StIdle);

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q & op_q;
    assign wb_sel_o = {4{cyc_q}};
    assign wb_dat_o = dat_word;
    assign wb_adr_o = (ADDR_ALIGN != 0) ? {adr_word[31:2], 2'b00} : adr_word;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: expected WB cycles and tx bytes are queued by the
// stimulus and checked by independent monitors on the falling clock edge.
module tb_uart_wb_bridge;

    localparam int SlvAck    = 0;
    localparam int SlvErr    = 1;
    localparam int SlvBoth   = 2;
    localparam int SlvSilent = 3;
    localparam int SlvHang   = 4;

    typedef struct packed {
        logic        we;
        logic        chk_dat;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int slv_mode = SlvAck;
    logic [31:0] rd_data = 32'h0;
    int tx_cnt = 0;

    logic [7:0] exp_tx[$];
    wb_exp_t    exp_wb[$];

    always #5 clk = ~clk;

    uart_wb_bridge #(
        .TIMEOUT_CYCLES (8),
        .ADDR_ALIGN     (1)
    ) dut (
        .clk_sys_i     (clk),
        .reset_sys_n_i (rst_n),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_ready_o    (rx_ready),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .wb_adr_o      (wb_adr),
        .wb_dat_o      (wb_dat_o),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_o      (wb_sel),
        .wb_we_o       (wb_we),
        .wb_cyc_o      (wb_cyc),
        .wb_stb_o      (wb_stb),
        .wb_ack_i      (wb_ack),
        .wb_err_i      (wb_err),
        .busy_o        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wishbone slave model and bus-cycle checker.
    logic seen = 1'b0;
    int   stb_cnt = 0;
    always @(negedge clk) begin
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_i = rd_data;
        if (!rst_n) begin
            seen    = 1'b0;
            stb_cnt = 0;
        end else if (wb_cyc && wb_stb) begin
            if (!seen) begin
                seen = 1'b1;
                if (exp_wb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got cycle adr %h, expected none", wb_adr);
                end else begin
                    wb_exp_t e;
                    e = exp_wb.pop_front();
                    check("wb_adr", wb_adr, e.adr);
                    check("wb_we", {31'b0, wb_we}, {31'b0, e.we});
                    check("wb_sel", {28'b0, wb_sel}, 32'hF);
                    if (e.chk_dat) check("wb_dat", wb_dat_o, e.dat);
                end
            end
            stb_cnt++;
            case (slv_mode)
                SlvAck:  wb_ack = 1'b1;
                SlvErr:  wb_err = 1'b1;
                SlvBoth: begin wb_ack = 1'b1; wb_err = 1'b1; end
                default: ;
            endcase
        end else begin
            if (stb_cnt != 0 && slv_mode == SlvSilent) check("timeout_len", stb_cnt, 8);
            seen    = 1'b0;
            stb_cnt = 0;
        end
    end

    // Transmit-side monitor: pops on handshake, checks data stays put while stalled.
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid) begin
                if (stalled) check("tx_hold", {24'b0, tx_data}, {24'b0, held});
                if (tx_ready) begin
                    stalled = 1'b0;
                    tx_cnt++;
                    if (exp_tx.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL tx_unexpected: got %h, expected none", tx_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_tx.pop_front();
                        check("tx_byte", {24'b0, tx_data}, {24'b0, e});
                    end
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (k == 200) check("rx_ready_timeout", {31'b0, rx_ready}, 32'h1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && exp_wb.size() == 0) break;
        end
        check("done", {31'b0, busy}, 32'h0);
    endtask

    task automatic push_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wb_exp_t e;
        e.we      = we;
        e.chk_dat = we;
        e.adr     = adr;
        e.dat     = dat;
        exp_wb.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #3;
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'h0);
        check("rst_sel", {28'b0, wb_sel}, 32'h0);
        check("rst_adr", wb_adr, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_rx_ready_low", {31'b0, rx_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("rel_rx_ready_high", {31'b0, rx_ready}, 32'h1);

        // Write: 57 00 00 10 04 DE AD BE EF -> K
        slv_mode = SlvAck;
        push_wb(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_word(32'h0000_1004);
        send_word(32'hDEAD_BEEF);
        wait_done();

        // Read with a 5-cycle stall after the 2nd response byte.
        rd_data = 32'h1234_5678;
        push_wb(1'b0, 32'h0000_1004, 32'h0);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h78);
        k = tx_cnt;
        send_byte(8'h52);
        send_word(32'h0000_1004);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_cnt >= k + 2) break;
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_done();

        // Error response; unaligned address gets its low bits cleared.
        slv_mode = SlvErr;
        push_wb(1'b0, 32'h0000_1008, 32'h0);
        exp_tx.push_back(8'h45);
        send_byte(8'h52);
        send_word(32'h0000_100B);
        wait_done();

        // Silent slave: 8-cycle timeout then 'T'.
        slv_mode = SlvSilent;
        push_wb(1'b0, 32'h0000_2000, 32'h0);
        exp_tx.push_back(8'h54);
        send_byte(8'h52);
        send_word(32'h0000_2000);
        wait_done();

        // Ack and err together: error wins, single 'E'.
        slv_mode = SlvBoth;
        push_wb(1'b1, 32'h0000_2004, 32'h5555_AAAA);
        exp_tx.push_back(8'h45);
        send_byte(8'h57);
        send_word(32'h0000_2004);
        send_word(32'h5555_AAAA);
        wait_done();

        // Unknown opcode, then a normal write.
        slv_mode = SlvAck;
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        wait_done();
        push_wb(1'b1, 32'h0000_2008, 32'hCAFE_BABE);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_word(32'h0000_2008);
        send_word(32'hCAFE_BABE);
        wait_done();

        // Reset while the bus cycle is outstanding: nothing may be transmitted.
        slv_mode = SlvHang;
        push_wb(1'b0, 32'h0000_3000, 32'h0);
        send_byte(8'h52);
        send_word(32'h0000_3000);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wb_stb) break;
        end
        check("hang_stb_high", {31'b0, wb_stb}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("mid_rst_adr", wb_adr, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        slv_mode = SlvAck;
        push_wb(1'b1, 32'h0000_3004, 32'h0BAD_F00D);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_word(32'h0000_3004);
        send_word(32'h0BAD_F00D);
        wait_done();

        repeat (10) @(negedge clk);
        check("tx_queue_drained", exp_tx.size(), 32'h0);
        check("wb_queue_drained", exp_wb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
